// File: rtl/alu_exec_stage.sv
// Execute stage behind the ALU control unit: single-cycle ALU/compare/branch ops.
// Shifts run one bit per cycle, so the datapath needs no barrel shifter.

package alu_exec_pkg;
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLT  = 5'd5,
    OP_SLTU = 5'd6,
    OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,
    OP_SRA  = 5'd9,
    OP_BEQ  = 5'd10,
    OP_BNE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BGE  = 5'd13,
    OP_BLTU = 5'd14,
    OP_BGEU = 5'd15,
    OP_ERR  = 5'd16
  } operation_t;
endpackage

module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               in_valid,
  output logic               in_ready,
  input  operation_t         op,
  input  logic               ctrl_err,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               branch_taken,
  output logic               alu_err,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t               state_p1;
  state_t               state_nxt;
  logic [WIDTH-1:0]     work_p1;
  logic [SHAMT_W-1:0]   cnt_p1;
  operation_t           shift_op_p1;
  logic [WIDTH-1:0]     result_p1;
  logic                 branch_p1;
  logic                 err_p1;

  logic                 accept_p0;
  logic                 is_shift_p0;
  logic                 is_err_p0;
  logic [SHAMT_W-1:0]   shamt_p0;

  function automatic logic op_is_legal(input operation_t o);
    logic ok;
    ok = 1'b0;
    case (o)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
      OP_SLL, OP_SRL, OP_SRA,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [WIDTH-1:0] alu_compute(input operation_t o,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic branch_eval(input operation_t o,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    t;
    sa = a;
    sb = b;
    t  = 1'b0;
    case (o)
      OP_BEQ:  t = (a == b);
      OP_BNE:  t = (a != b);
      OP_BLT:  t = (sa < sb);
      OP_BGE:  t = (sa >= sb);
      OP_BLTU: t = (a < b);
      OP_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input operation_t o,
                                                  input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = v;
    case (o)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      default: r = sv >>> 1;
    endcase
    return r;
  endfunction

  // Stage p0: accept decision and decode of the incoming op
  assign in_ready    = nrst && !flush &&
                       ((state_p1 == IDLE) || ((state_p1 == DONE) && out_ready));
  assign accept_p0   = in_valid && in_ready;
  assign shamt_p0    = src_b[SHAMT_W-1:0];
  assign is_shift_p0 = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign is_err_p0   = ctrl_err || !op_is_legal(op);

  always_comb begin
    state_nxt = state_p1;
    if (flush) begin
      state_nxt = IDLE;
    end else if (accept_p0) begin
      state_nxt = (!is_err_p0 && is_shift_p0 && (shamt_p0 != '0)) ? SHIFT : DONE;
    end else begin
      case (state_p1)
        SHIFT:   if (cnt_p1 == CNT_ONE) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) state_p1 <= IDLE;
    else       state_p1 <= state_nxt;
  end

  // Stage p1: registered outputs and the iterative shift engine
  always_ff @(posedge clk) begin
    if (!nrst || flush) begin
      work_p1     <= '0;
      cnt_p1      <= '0;
      shift_op_p1 <= OP_SLL;
      result_p1   <= '0;
      branch_p1   <= 1'b0;
      err_p1      <= 1'b0;
    end else if (accept_p0) begin
      shift_op_p1 <= op;
      if (is_err_p0) begin
        result_p1 <= '0;
        branch_p1 <= 1'b0;
        err_p1    <= 1'b1;
      end else if (is_shift_p0) begin
        branch_p1 <= 1'b0;
        err_p1    <= 1'b0;
        if (shamt_p0 == '0) begin
          result_p1 <= src_a;
        end else begin
          work_p1   <= src_a;
          cnt_p1    <= shamt_p0;
          result_p1 <= '0;
        end
      end else begin
        result_p1 <= alu_compute(op, src_a, src_b);
        branch_p1 <= branch_eval(op, src_a, src_b);
        err_p1    <= 1'b0;
      end
    end else if (state_p1 == SHIFT) begin
      work_p1 <= shift_step(shift_op_p1, work_p1);
      cnt_p1  <= cnt_p1 - CNT_ONE;
      // Last step lands straight in the result register as DONE is entered
      if (cnt_p1 == CNT_ONE) result_p1 <= shift_step(shift_op_p1, work_p1);
    end
  end

  assign out_valid    = (state_p1 == DONE);
  assign busy         = (state_p1 != IDLE);
  assign result       = result_p1;
  assign branch_taken = branch_p1;
  assign alu_err      = err_p1;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table for single ops plus
// hand-written sequences for back-to-back, backpressure, flush and reset.

module tb_alu_exec_stage;
  import alu_exec_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             nrst;
  logic             in_valid;
  logic             in_ready;
  operation_t       op;
  logic             ctrl_err;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             branch_taken;
  logic             alu_err;
  logic             busy;

  int total = 0;
  int bad   = 0;

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ctrl_err(ctrl_err), .src_a(src_a), .src_b(src_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_taken(branch_taken), .alu_err(alu_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    operation_t  op;
    logic        ctrl_err;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_bt;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op with out_ready=1, measure latency, check outputs, drain to IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = v.op; ctrl_err = v.ctrl_err; src_a = v.a; src_b = v.b;
    out_ready = 1'b1;
    chk($sformatf("v%0d in_ready", idx), {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; ctrl_err = 1'b0;
    src_a = '1; src_b = '1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d result", idx), result, v.exp_res);
    chk($sformatf("v%0d branch", idx), {31'b0, branch_taken}, {31'b0, v.exp_bt});
    chk($sformatf("v%0d alu_err", idx), {31'b0, alu_err}, {31'b0, v.exp_err});
    @(negedge clk);
    chk($sformatf("v%0d idle", idx), {30'b0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0; in_valid = 1'b0; op = OP_ADD; ctrl_err = 1'b0;
    src_a = '0; src_b = '0; flush = 1'b0; out_ready = 1'b0;

    vecs.push_back('{OP_ADD,  1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SRA,  1'b0, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b0, 5});
    vecs.push_back('{OP_SRL,  1'b0, 32'h80000000, 32'h4,        32'h08000000, 1'b0, 1'b0, 5});
    vecs.push_back('{OP_SLL,  1'b0, 32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0, 32});
    vecs.push_back('{OP_SLL,  1'b0, 32'h1234,     32'h20,       32'h1234,     1'b0, 1'b0, 1});
    vecs.push_back('{OP_SRA,  1'b0, 32'h40000000, 32'h21,       32'h20000000, 1'b0, 1'b0, 2});
    vecs.push_back('{OP_BLT,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{OP_BLTU, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1});
    vecs.push_back('{OP_BGEU, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{OP_BNE,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{OP_BGE,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1});
    vecs.push_back('{OP_BEQ,  1'b0, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{OP_SLT,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLTU, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1});
    vecs.push_back('{OP_XOR,  1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_OR,   1'b0, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, 1});
    vecs.push_back('{OP_ADD,  1'b1, 32'h5,        32'h6,        32'h0,        1'b0, 1'b1, 1});
    vecs.push_back('{OP_ERR,  1'b0, 32'h5,        32'h6,        32'h0,        1'b0, 1'b1, 1});
    vecs.push_back('{OP_BEQ,  1'b1, 32'h7,        32'h7,        32'h0,        1'b0, 1'b1, 1});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst outputs", {28'b0, out_valid, branch_taken, alu_err, busy}, 32'd0);
    chk("rst result", result, 32'd0);
    in_valid = 1'b0;
    nrst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back ADD then SUB with no bubble
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; src_a = 32'h7FFFFFFF; src_b = 32'h1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b add valid", {31'b0, out_valid}, 32'd1);
    chk("b2b add result", result, 32'h80000000);
    op = OP_SUB; src_a = 32'd5; src_b = 32'd7;
    chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b sub valid", {31'b0, out_valid}, 32'd1);
    chk("b2b sub result", result, 32'hFFFFFFFE);
    @(negedge clk);
    chk("b2b drain", {31'b0, out_valid}, 32'd0);

    // Backpressure: result held while out_ready=0, new op not accepted
    in_valid = 1'b1; op = OP_AND; src_a = 32'hF0F0; src_b = 32'hFF00; out_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      src_a = 32'h1111 * (k + 1); op = OP_OR;
      chk($sformatf("bp%0d hold", k), {30'b0, out_valid, in_ready}, 32'd2);
      chk($sformatf("bp%0d result", k), result, 32'hF000);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp idle", {30'b0, out_valid, busy}, 32'd0);
    chk("bp result kept", result, 32'hF000);

    // Flush on cycle 3 of a 10-bit SLL, with in_valid asserted alongside flush
    in_valid = 1'b1; op = OP_SLL; src_a = 32'h1; src_b = 32'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sh in_ready low", {30'b0, in_ready, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; src_a = 32'd3; src_b = 32'd4;
    chk("flush in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush state", {30'b0, out_valid, busy}, 32'd0);
    chk("flush result", result, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (out_valid || busy) seen++;
      end
      chk("flush quiet", seen, 0);
    end
    run_vec('{OP_ADD, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1}, 100);

    // Reset in the middle of a shift, after a prior error left alu_err set
    run_vec('{OP_ERR, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1}, 101);
    @(negedge clk);
    in_valid = 1'b1; op = OP_SLL; src_a = 32'h1; src_b = 32'd8;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b0;
    chk("midrst in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst outputs", {28'b0, out_valid, branch_taken, alu_err, busy}, 32'd0);
    chk("midrst result", result, 32'd0);
    nrst = 1'b1;
    run_vec('{OP_SUB, 1'b0, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1}, 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage that sits directly downstream of the ALU control unit. It consumes the decoded operation_t, that unit's ctrl_err flag and two operands.
- Produces a registered result and a branch decision over a valid/ready handshake.
- Single-cycle for arithmetic, logic, compare and branch ops.
- Iterative, one bit per cycle, for shifts (SLL/SRL/SRA), so no barrel shifter in the datapath.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, $clog2(WIDTH), shift-amount width taken from src_b[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  synchronous active-low reset
- in_valid  in  1  upstream presents op/operands
- in_ready  out  1  stage can accept this cycle
- op  in  operation_t  operation from the ALU control unit
- ctrl_err  in  1  decode error from the ALU control unit
- src_a  in  WIDTH  operand A (rs1)
- src_b  in  WIDTH  operand B (rs2 or immediate)
- flush  in  1  synchronous pipeline kill
- out_valid  out  1  result/branch_taken/alu_err valid
- out_ready  in  1  downstream accepts the output
- result  out  WIDTH  computed value
- branch_taken  out  1  branch condition true (branch ops only)
- alu_err  out  1  operation was ERR or ctrl_err was set
- busy  out  1  state != IDLE

Behaviour:
- The only clock is clk. Reset is synchronous and active-low on nrst.
- Reset (nrst=0 at a rising edge):
  - State returns to IDLE.
  - out_valid=0, result=0, branch_taken=0, alu_err=0, busy=0.
  - in_ready is low while nrst=0.
- FSM states are IDLE, SHIFT and DONE.
- Accept condition: in_valid && in_ready at the rising edge.
  - in_ready = nrst && !flush && (state==IDLE || (state==DONE && out_ready)).
  - This allows back-to-back issue with no bubble.
- Non-shift ops:
  - Result is computed at accept and registered; next state is DONE.
  - out_valid rises 1 cycle after accept.
- ADD/SUB: modulo 2^WIDTH, overflow ignored.
- AND/OR/XOR: bitwise.
- SLT: signed compare. SLTU: unsigned compare. Both give a zero-extended 0/1.
- Branch ops:
  - result=0; branch_taken per the comparison below.
  - BEQ: a==b. BNE: a!=b. BLT: signed a<b. BGE: signed a>=b. BLTU: unsigned a<b. BGEU: unsigned a>=b.
  - All non-branch ops output branch_taken=0.
- ERR op or ctrl_err=1:
  - result=0, branch_taken=0, alu_err=1; 1-cycle latency.
  - ctrl_err has priority over op.
- Shift ops, with shamt = src_b[SHAMT_W-1:0] and upper bits of src_b ignored:
  - shamt==0: result=src_a, DONE after 1 cycle.
  - shamt>0: load a working register with src_a and a counter with shamt, then enter SHIFT.
  - Each SHIFT cycle shifts by one bit and decrements the counter.
  - SLL fills zeros on the left shift. SRL fills zeros at the MSB. SRA replicates the MSB.
  - When the counter reaches 0, the working register is copied to result and the state moves to DONE.
  - out_valid rises shamt+1 cycles after accept; in_ready=0 throughout SHIFT.
- DONE:
  - out_valid=1.
  - result, branch_taken and alu_err are held stable while out_ready=0.
  - On out_ready=1 with no new accept: go to IDLE, out_valid=0 next cycle.
  - On out_ready=1 with an accept in the same cycle: the new op is processed directly (DONE again, or SHIFT).
- Flush:
  - Has priority over everything except reset.
  - At the edge, state goes to IDLE, out_valid=0, and any in-flight shift is discarded.
  - in_ready is low in the flush cycle, so no accept occurs.
  - result, branch_taken and alu_err are cleared to 0.
- Operands and op are sampled only at accept. Upstream changes during SHIFT/DONE have no effect.
- A reset mid-shift behaves as a flush plus full register clear.
- busy=1 in SHIFT and DONE.

Test Plan:
1. Reset, then ADD a=0x7FFFFFFF, b=1 with out_ready=1 -> out_valid 1 cycle after accept, result=0x80000000, alu_err=0; then SUB a=5, b=7 back-to-back -> result=0xFFFFFFFE in the next cycle, no bubble.
2. SRA a=0x80000000, shamt=4 -> in_ready=0 for 4 cycles, out_valid 5 cycles after accept, result=0xF8000000. SRL same operands -> 0x08000000. SLL a=1, shamt=31 -> 0x80000000 after 32 cycles. Shift with src_b=0x20 (shamt 0) -> result=src_a after 1 cycle.
3. Branches with a=0xFFFFFFFF, b=1 -> BLT taken=1, BLTU taken=0, BGEU taken=1, BNE taken=1, and result=0 each time; BEQ a=b=0x1234 -> taken=1; SLT -> 1, SLTU -> 0 with the same operands.
4. Backpressure: issue AND a=0xF0F0, b=0xFF00 with out_ready=0 for 3 cycles -> result=0xF000 held, out_valid=1, in_ready=0; deassert in_valid and raise out_ready -> IDLE next cycle.
5. Flush on cycle 3 of a 10-bit SLL -> out_valid never asserts, state IDLE next cycle, busy=0, next ADD accepted normally. in_valid together with flush -> not accepted.
6. ctrl_err=1 with op=ADD, and separately op=ERR -> alu_err=1, result=0, branch_taken=0 after 1 cycle; nrst=0 mid-SHIFT -> all outputs 0 at the next edge.
